// File: rtl/i2c_master.sv
// i2c_master: single-byte I2C bus master.
// Issues START, one address/RW byte, one data byte (write or read) and STOP,
// then pulses o_done. SCL is push-pull, SDA is open-drain (driven 0 or released).
//
// Handshake: i_start acts as a request that is accepted only on a rising edge
// while the master is idle (o_state == 0). Once accepted, all inputs are latched
// and further i_start pulses are ignored until o_done has pulsed for exactly one
// cycle and the master has returned to idle.
module i2c_master #(
    parameter int QDIV = 1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_Data,
    input  logic [7:0] i_addr,
    input  logic       i_rw,
    input  logic       i_start,
    inout  wire        io_sda,
    output logic       o_done,
    output logic [7:0] o_data,
    output logic       o_scl,
    output logic [3:0] o_state
);

    localparam int DW = (QDIV > 1) ? $clog2(QDIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(QDIV - 1);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_START = 4'd1,
        S_ADDR  = 4'd2,
        S_ACK1  = 4'd3,
        S_WDATA = 4'd4,
        S_ACK2  = 4'd5,
        S_RDATA = 4'd6,
        S_MNACK = 4'd7,
        S_STOP  = 4'd8,
        S_DONE  = 4'd9
    } state_t;

    state_t          r_state;
    logic [DW-1:0]   r_div;
    logic [1:0]      r_q;
    logic [2:0]      r_bit;
    logic [7:0]      r_abyte;
    logic [7:0]      r_wbyte;
    logic            r_rw;
    logic [7:0]      r_rx;
    logic            r_nack;
    logic            r_scl;
    logic            r_sda_low;
    logic            r_done;
    logic [7:0]      r_data;

    logic            w_tick;
    logic            w_sda_in;
    logic            w_q1_low;
    state_t          w_next_state;
    logic [2:0]      w_next_bit;
    logic            w_unused;

    // Address bit 0 is replaced by the RW flag, so the input bit is never used.
    assign w_unused = i_addr[0];

    // Quarter-period tick; with QDIV=1 every cycle is a quarter.
    assign w_tick = (r_div == DIV_MAX);

    // Anything other than a solid 0 on the bus (released or floating) reads as 1.
    assign w_sda_in = (io_sda !== 1'b0);

    // Open-drain SDA: only ever pull low or release.
    assign io_sda  = r_sda_low ? 1'b0 : 1'bz;
    assign o_scl   = r_scl;
    assign o_done  = r_done;
    assign o_data  = r_data;
    assign o_state = r_state;

    // SDA level the master applies at the start of q1 of the current bit.
    always_comb begin
        w_q1_low = 1'b0;
        case (r_state)
            S_START: w_q1_low = 1'b1;
            S_ADDR:  w_q1_low = ~r_abyte[3'd7 - r_bit];
            S_WDATA: w_q1_low = ~r_wbyte[3'd7 - r_bit];
            S_STOP:  w_q1_low = 1'b1;
            default: w_q1_low = 1'b0;
        endcase
    end

    // State and bit index to move to when the current bit period ends.
    always_comb begin
        w_next_state = r_state;
        w_next_bit   = r_bit + 3'd1;
        case (r_state)
            S_START: begin
                w_next_state = S_ADDR;
                w_next_bit   = 3'd0;
            end
            S_ADDR: begin
                if (r_bit == 3'd7) w_next_state = S_ACK1;
            end
            S_ACK1: begin
                w_next_bit = 3'd0;
                if (r_nack)    w_next_state = S_STOP;
                else if (r_rw) w_next_state = S_RDATA;
                else           w_next_state = S_WDATA;
            end
            S_WDATA: begin
                if (r_bit == 3'd7) w_next_state = S_ACK2;
            end
            S_ACK2:  w_next_state = S_STOP;
            S_RDATA: begin
                if (r_bit == 3'd7) w_next_state = S_MNACK;
            end
            S_MNACK: w_next_state = S_STOP;
            S_STOP:  w_next_state = S_DONE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Main FSM: quarter sequencing, bus outputs, sampling and completion.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_div     <= '0;
            r_q       <= 2'd0;
            r_bit     <= 3'd0;
            r_abyte   <= 8'h00;
            r_wbyte   <= 8'h00;
            r_rw      <= 1'b0;
            r_rx      <= 8'h00;
            r_nack    <= 1'b0;
            r_scl     <= 1'b1;
            r_sda_low <= 1'b0;
            r_done    <= 1'b0;
            r_data    <= 8'h00;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_scl     <= 1'b1;
                    r_sda_low <= 1'b0;
                    if (i_start) begin
                        r_state   <= S_START;
                        r_abyte   <= {i_addr[7:1], i_rw};
                        r_wbyte   <= i_Data;
                        r_rw      <= i_rw;
                        r_div     <= '0;
                        r_q       <= 2'd0;
                        r_bit     <= 3'd0;
                        // START condition: SDA falls while SCL stays high.
                        r_sda_low <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    if (!w_tick) begin
                        r_div <= r_div + DW'(1);
                    end else begin
                        r_div <= '0;
                        r_q   <= r_q + 2'd1;
                        case (r_q)
                            2'd0: begin
                                // Entering q1: SCL is low, safe to change SDA.
                                r_sda_low <= w_q1_low;
                            end
                            2'd1: begin
                                // Entering q2: SCL rises, except START which drops it.
                                r_scl <= (r_state != S_START);
                            end
                            2'd2: begin
                                // Entering q3: SCL high and SDA settled.
                                if (r_state == S_ACK1)  r_nack <= w_sda_in;
                                if (r_state == S_RDATA) r_rx   <= {r_rx[6:0], w_sda_in};
                                if (r_state == S_STOP)  r_sda_low <= 1'b0;
                            end
                            default: begin
                                // End of bit: advance; STOP leaves SCL high and finishes.
                                r_state <= w_next_state;
                                r_bit   <= w_next_bit;
                                if (r_state == S_STOP) begin
                                    r_done <= 1'b1;
                                    if (r_rw && !r_nack) r_data <= r_rx;
                                end else begin
                                    r_scl <= 1'b0;
                                end
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master.sv
// tb_i2c_master: directed vector bench for i2c_master with a bus monitor and
// a simple I2C slave model on an open-drain SDA line with pull-up.
module tb_i2c_master;

    localparam int QDIV = 1;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       i_start;
    logic       i_rw;
    logic [7:0] i_Data;
    logic [7:0] i_addr;
    logic       o_done;
    logic       o_scl;
    logic [7:0] o_data;
    logic [3:0] o_state;
    wire        sda_bus;

    logic       slv_low;
    pullup (sda_bus);
    assign sda_bus = slv_low ? 1'b0 : 1'bz;

    i2c_master #(.QDIV(QDIV)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_Data  (i_Data),
        .i_addr  (i_addr),
        .i_rw    (i_rw),
        .i_start (i_start),
        .io_sda  (sda_bus),
        .o_done  (o_done),
        .o_data  (o_data),
        .o_scl   (o_scl),
        .o_state (o_state)
    );

    // ---------------- bus monitor and slave model ----------------
    int         cyc;
    int         start_cnt;
    int         stop_cnt;
    int         done_cnt;
    int         done_cyc;
    logic [7:0] done_data;
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    logic       bits_q[$];

    logic       slv_ack_addr;
    logic       slv_ack_data;
    logic       slv_read;
    logic [7:0] slv_byte;

    always @(posedge clk) cyc <= cyc + 1;

    // Bit n of a frame: 0-7 address, 8 ACK1, 9-16 data, 17 ACK2/NACK, then STOP.
    function automatic logic slave_drive(input int n);
        if (n == 8) return slv_ack_addr;
        if (n >= 9 && n <= 16 && slv_read && slv_ack_addr) return !slv_byte[16 - n];
        if (n == 17 && !slv_read) return slv_ack_data;
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        prev_scl <= o_scl;
        prev_sda <= sda_bus;
        if (prev_scl && o_scl && prev_sda && !sda_bus) begin
            start_cnt <= start_cnt + 1;
            bits_q.delete();
        end
        if (prev_scl && o_scl && !prev_sda && sda_bus) stop_cnt <= stop_cnt + 1;
        if (!prev_scl && o_scl) bits_q.push_back(sda_bus);
        if (o_done) begin
            done_cnt  <= done_cnt + 1;
            done_cyc  <= cyc;
            done_data <= o_data;
        end
        if (!rst_n) slv_low <= 1'b0;
        else if (prev_scl && !o_scl) slv_low <= slave_drive(bits_q.size());
    end

    // ---------------- scoreboard ----------------
    int n_checks;
    int n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] addr;
        logic       rw;
        logic [7:0] data;
        logic       ack_addr;
        logic       ack_data;
        logic [7:0] rd_byte;
        logic       busy_start;
        logic [7:0] exp_abyte;
        logic       exp_ack1;
        logic [7:0] exp_dbyte;
        logic       exp_ack2;
        int         exp_len;
        int         exp_lat;
        logic [7:0] exp_odata;
    } vec_t;

    // ---------------- driver ----------------
    task automatic run_txn(input vec_t v, input string tag);
        int         t0;
        int         d0;
        int         s0;
        int         p0;
        int         k;
        logic [8:0] obs;
        logic [8:0] exp_q[$];

        slv_ack_addr = v.ack_addr;
        slv_ack_data = v.ack_data;
        slv_read     = v.rw;
        slv_byte     = v.rd_byte;

        @(negedge clk);
        i_addr  = v.addr;
        i_rw    = v.rw;
        i_Data  = v.data;
        i_start = 1'b1;
        t0 = cyc;
        d0 = done_cnt;
        s0 = start_cnt;
        p0 = stop_cnt;
        @(negedge clk);
        i_start = 1'b0;
        i_addr  = ~v.addr;
        i_rw    = ~v.rw;
        i_Data  = ~v.data;

        if (v.busy_start) begin
            repeat (30) @(negedge clk);
            i_Data  = 8'hFF;
            i_start = 1'b1;
            @(negedge clk);
            i_start = 1'b0;
        end

        k = 0;
        while (done_cnt == d0 && k < 300) begin
            @(posedge clk);
            k++;
        end
        check({tag, "_done_seen"}, 32'(done_cnt != d0), 32'd1);
        repeat (8) @(negedge clk);

        check({tag, "_latency"}, 32'(done_cyc - (t0 + 1)), 32'(v.exp_lat));
        check({tag, "_done_count"}, 32'(done_cnt - d0), 32'd1);
        check({tag, "_start_count"}, 32'(start_cnt - s0), 32'd1);
        check({tag, "_stop_count"}, 32'(stop_cnt - p0), 32'd1);
        check({tag, "_data_at_done"}, 32'(done_data), 32'(v.exp_odata));
        check({tag, "_data_hold"}, 32'(o_data), 32'(v.exp_odata));
        check({tag, "_frame_bits"}, 32'(bits_q.size()), 32'(v.exp_len));

        exp_q.push_back({v.exp_abyte, v.exp_ack1});
        if (v.exp_len == 19) exp_q.push_back({v.exp_dbyte, v.exp_ack2});
        if (bits_q.size() == v.exp_len) begin
            for (int w = 0; w < v.exp_len / 9; w++) begin
                obs = '0;
                for (int b = 0; b < 9; b++) obs = {obs[7:0], bits_q[9 * w + b]};
                check($sformatf("%s_word%0d", tag, w), 32'(obs), 32'(exp_q.pop_front()));
            end
            check({tag, "_stop_bit"}, 32'(bits_q[v.exp_len - 1]), 32'd0);
        end

        check({tag, "_idle_scl"}, 32'(o_scl), 32'd1);
        check({tag, "_idle_sda"}, 32'(sda_bus), 32'd1);
        check({tag, "_idle_state"}, 32'(o_state), 32'd0);
        i_addr = 8'h00;
        i_rw   = 1'b0;
        i_Data = 8'h00;
    endtask

    // ---------------- test ----------------
    vec_t vecs[7];
    vec_t post;

    initial begin
        // addr rw data ackA ackD rd busy | abyte ack1 dbyte ack2 len lat odata
        vecs[0] = '{8'hB7, 1'b0, 8'h2E, 1'b1, 1'b1, 8'h00, 1'b0, 8'hB6, 1'b0, 8'h2E, 1'b0, 19, 80, 8'h00};
        vecs[1] = '{8'hB7, 1'b1, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b0, 8'hB7, 1'b0, 8'hA5, 1'b1, 19, 80, 8'hA5};
        vecs[2] = '{8'h50, 1'b0, 8'h3C, 1'b0, 1'b0, 8'h00, 1'b0, 8'h50, 1'b1, 8'h00, 1'b0, 10, 44, 8'hA5};
        vecs[3] = '{8'h42, 1'b0, 8'h81, 1'b1, 1'b0, 8'h00, 1'b0, 8'h42, 1'b0, 8'h81, 1'b1, 19, 80, 8'hA5};
        vecs[4] = '{8'h90, 1'b1, 8'h00, 1'b1, 1'b0, 8'h3C, 1'b0, 8'h91, 1'b0, 8'h3C, 1'b1, 19, 80, 8'h3C};
        vecs[5] = '{8'h21, 1'b0, 8'h5A, 1'b1, 1'b1, 8'h00, 1'b1, 8'h20, 1'b0, 8'h5A, 1'b0, 19, 80, 8'h3C};
        vecs[6] = '{8'h0E, 1'b1, 8'h00, 1'b0, 1'b0, 8'h55, 1'b0, 8'h0F, 1'b1, 8'h00, 1'b0, 10, 44, 8'h3C};
        post    = '{8'hB7, 1'b0, 8'h2E, 1'b1, 1'b1, 8'h00, 1'b0, 8'hB6, 1'b0, 8'h2E, 1'b0, 19, 80, 8'h00};

        rst_n        = 1'b0;
        i_start      = 1'b0;
        i_rw         = 1'b0;
        i_Data       = 8'h00;
        i_addr       = 8'h00;
        slv_ack_addr = 1'b0;
        slv_ack_data = 1'b0;
        slv_read     = 1'b0;
        slv_byte     = 8'h00;

        repeat (3) @(negedge clk);
        check("reset_scl", 32'(o_scl), 32'd1);
        check("reset_sda", 32'(sda_bus), 32'd1);
        check("reset_done", 32'(o_done), 32'd0);
        check("reset_data", 32'(o_data), 32'd0);
        check("reset_state", 32'(o_state), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) run_txn(vecs[i], $sformatf("v%0d", i));

        // Asynchronous reset in the middle of ADDR bit 4 (SCL low, SDA low).
        slv_ack_addr = 1'b1;
        slv_ack_data = 1'b1;
        slv_read     = 1'b0;
        @(negedge clk);
        i_addr  = 8'hB7;
        i_rw    = 1'b0;
        i_Data  = 8'h2E;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (21) @(negedge clk);
        check("mid_pre_scl", 32'(o_scl), 32'd0);
        check("mid_pre_sda", 32'(sda_bus), 32'd0);
        check("mid_pre_state", 32'(o_state), 32'd2);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_scl", 32'(o_scl), 32'd1);
        check("mid_rst_sda", 32'(sda_bus), 32'd1);
        check("mid_rst_done", 32'(o_done), 32'd0);
        check("mid_rst_data", 32'(o_data), 32'd0);
        check("mid_rst_state", 32'(o_state), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        i_addr = 8'h00;
        i_Data = 8'h00;
        @(negedge clk);
        run_txn(post, "post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_master.md
Name: i2c_master

Overview:
- Single-byte I2C bus master.
- On an `i_start` pulse it issues START, one address/RW byte, one data byte (written or read) and STOP, then pulses `o_done`.
- SCL is generated internally from `i_clk`. SDA is open-drain on a bidirectional pin.
- Sits between a local controller and an external I2C slave; the bus needs an external pull-up.

Parameters:
- QDIV, 1, number of `i_clk` cycles per quarter SCL period (≥1). One SCL bit = 4·QDIV `i_clk` cycles.

Ports:
- `i_clk` in 1: system clock; all logic on rising edge.
- `i_rst_n` in 1: reset, asynchronous, active-low.
- `i_Data` in 8: byte to write (used when `i_rw`=0).
- `i_addr` in 8: slave address; bits [7:1] are the 7-bit address, bit 0 ignored.
- `i_rw` in 1: 1 = read, 0 = write.
- `i_start` in 1: transaction request, sampled high for ≥1 cycle.
- `io_sda` inout 1: I2C data. Driven 0 or released (high-Z) only, never driven 1.
- `o_done` out 1: one-cycle pulse at transaction end.
- `o_data` out 8: byte read from the slave.
- `o_scl` out 1: I2C clock, push-pull.

Behaviour:
- **Reset** (async, `i_rst_n`=0):
  - State IDLE; `o_scl`=1; SDA released; `o_done`=0; `o_data`=0; counters and shift registers cleared.
- **Start acceptance:**
  - `i_start` high on a rising edge in IDLE starts a transaction.
  - On that edge, latch address byte A = {`i_addr`[7:1], `i_rw`}, latch `i_Data`, and latch `i_rw`.
  - `i_start` is ignored outside IDLE.
  - Input changes after acceptance have no effect.
- **Bit timing:**
  - Quarter tick every QDIV cycles.
  - Each bit spans quarters q0..q3: SCL low in q0–q1, high in q2–q3.
  - Master changes SDA at the start of q1 (SCL low).
  - SDA is sampled at the start of q3 (SCL high).
  - A sampled value that is not 0 (released or Z) counts as 1.
- **States:**
  - **IDLE:** SCL=1, SDA released.
  - **START:** one bit period. SDA pulled low while SCL high for q0–q1, then SCL low.
  - **ADDR:** 8 bits of A, MSB first.
  - **ACK1:** SDA released; sample the slave ACK. 0 = ACK; else NACK → STOP.
  - **WDATA** (`i_rw`=0): 8 bits of `i_Data`, MSB first. Then **ACK2**: sample and ignore, then STOP.
  - **RDATA** (`i_rw`=1): SDA released; 8 bits shifted in MSB first. Then **MNACK**: master leaves SDA released (NACK, last byte), then STOP.
  - **STOP:** one bit period. SDA low while SCL rises, then SDA released while SCL high.
  - **DONE:** `o_done`=1 for exactly one cycle, then IDLE.
- **`o_data` update:**
  - Updated with the full received byte in the same cycle `o_done` pulses, for reads only.
  - Holds its value otherwise, including on NACK and on writes.
- **NACK on address:** still performs STOP and pulses `o_done`; `o_data` unchanged.
- **Reset mid-transaction:** immediate return to reset values; no STOP is generated.
- **Clock stretching and arbitration:** not supported. SCL is never sampled.
- **Latency:**
  - Write or read = 1 (START) + 8 + 1 + 8 + 1 + 1 (STOP) = 20 bit periods = 80·QDIV cycles from acceptance to `o_done`.
  - Address NACK: 11 bit periods = 44·QDIV cycles.

Test Plan:
1. **Reset:** hold `i_rst_n`=0 with a weak pull-up on `io_sda` → `o_scl`=1, `io_sda`=1 (released), `o_done`=0, `o_data`=0.
2. **Write** (QDIV=1, `i_addr`=8'hB7, `i_rw`=0, `i_Data`=8'h2E):
   - Stimulus: one-cycle `i_start`; slave pulls SDA low during both ACK bits.
   - Required: bus carries START, 8'hB6, ACK, 8'h2E, ACK, STOP.
   - Required: `o_done` pulses exactly once, 80 cycles after acceptance; `o_data` unchanged.
3. **Read** (`i_addr`=8'hB7, `i_rw`=1):
   - Stimulus: slave ACKs the address, then drives 8'hA5 MSB first during the SCL-low phases.
   - Required: address byte 8'hB7; master releases SDA in the 9th read bit; STOP follows; `o_data`=8'hA5 when `o_done` pulses.
4. **Address NACK:**
   - Stimulus: slave leaves SDA released at ACK1.
   - Required: STOP immediately after ACK1; `o_done` 44 cycles after acceptance; no data byte on the bus.
5. **Start while busy:**
   - Stimulus: pulse `i_start` again mid-transaction, with `i_Data` changed to 8'hFF.
   - Required: ignored; the original byte is sent; exactly one `o_done`.
6. **Async reset mid-transaction:**
   - Stimulus: drop `i_rst_n` during ADDR bit 4.
   - Required: outputs return to reset values immediately, without waiting for a clock edge.
   - Required: a subsequent `i_start` runs a complete transaction normally.
